multicycle_control: RTL
=======================

# multicycle_control

Sequencing controller for the multi-cycle variant of the MIPS datapath. Every instruction is split into fetch, decode, execute, memory and write-back steps over a shared ALU and a single unified memory port. The block is a Moore FSM plus a retired-instruction counter, and it drives every mux select and write enable of that datapath. It also absorbs memory wait states through a ready handshake and halts on illegal opcodes.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `opcode` input 6: instruction bits [31:26] from the instruction register.
- `zero` input 1: ALU zero flag, valid during BRANCH.
- `mem_ready` input 1: memory port completes the current access this cycle.
- `pc_en` output 1: PC load enable. Branch qualification is resolved internally.
- `i_or_d` output 1: 0 selects the PC as memory address; 1 selects ALUOut.
- `mem_read`, `mem_write` output 1 each: memory port strobes.
- `ir_write` output 1: instruction register load.
- `reg_dst` output 1: 1 selects rd; 0 selects rt.
- `mem_to_reg` output 1: 1 selects MDR; 0 selects ALUOut.
- `reg_write` output 1: register file write enable.
- `alu_src_a` output 1: 0 selects PC; 1 selects register A.
- `alu_src_b` output 2: operand B select.
- `alu_op` output 2: operation class for the ALU control unit.
- `pc_source` output 2: next-PC select.
- `halted` output 1: high in the HALT state.
- `state` output 4: current state encoding, for debug.
- `retired` output CNT_W: count of completed instructions.

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, HALT=12.
- Transitions:
  - FETCH goes to DECODE when mem_ready=1; otherwise it stays in FETCH.
  - DECODE dispatches on opcode:
    - 0x23 (lw) or 0x2B (sw) go to MEMADR.
    - 0x00 (R-type) goes to EXEC.
    - 0x04 (beq) or 0x05 (bne) go to BRANCH.
    - 0x02 (j) goes to JUMP.
    - 0x08 (addi) goes to ADDI_EX.
    - Any other opcode goes to HALT.
  - MEMADR goes to MEMRD for lw and to MEMWR for sw.
  - MEMRD goes to MEMWB on mem_ready; otherwise it stays.
  - MEMWR goes to FETCH on mem_ready; otherwise it stays.
  - MEMWB, RWB, ADDI_WB, BRANCH and JUMP go to FETCH.
  - EXEC goes to RWB; ADDI_EX goes to ADDI_WB.
  - HALT stays in HALT until rst.
- The opcode is captured into an internal register in DECODE. Later states use the captured copy, not the live input.
- Control word per state (unlisted signals are 0):
  - FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_en equal mem_ready.
  - DECODE: alu_src_b=11, alu_op=00. This computes the branch target.
  - MEMADR and ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD: mem_read=1, i_or_d=1.
  - MEMWR: mem_write=1, i_or_d=1.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - RWB: reg_write=1, reg_dst=1, mem_to_reg=0.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. pc_en=zero for beq and pc_en=~zero for bne.
  - JUMP: pc_source=10, pc_en=1.
  - HALT: halted=1; all enables are 0.
- `retired` increments by 1 on the edge leaving MEMWB, MEMWR (with mem_ready=1), RWB, ADDI_WB, BRANCH or JUMP.
  - The increment applies whether or not a branch is taken.
  - The counter wraps modulo 2^CNT_W.
  - HALT does not count.

## Timing
- Reset:
  - On a rising edge with rst=1: state becomes FETCH, retired becomes 0, the captured opcode becomes 0.
  - Reset takes priority over every transition, including mid-instruction and in HALT.
- While rst=1, pc_en, ir_write, mem_read, mem_write and reg_write are forced to 0 combinationally.
- Outputs are combinational from state. The exceptions are ir_write and pc_en in FETCH, which depend on mem_ready, and pc_en in BRANCH, which depends on zero.
- Latency in cycles with zero wait states:
  - lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j 3.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. All outputs hold steady during a stall.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.

## Structure
- Package `mc_pkg` holds:
  - the state enum;
  - opcode constants;
  - alu_op codes: 00 add, 01 sub, 10 funct;
  - alu_src_b codes: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left by 2;
  - pc_source codes: 00 ALU result, 01 ALUOut, 10 jump target.
- One sub-module, `mc_output_decode`, maps state, captured opcode, zero and mem_ready to the control word.
- The top level holds the state register, the opcode register and the retired counter.

## Test plan
- Reset held 2 cycles with mem_ready=1 -> state=0 and retired=0. All write enables are 0 during reset. ir_write=1 in the first post-reset cycle.
- lw (0x23) with mem_ready=1 -> state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in cycle 5; retired=1.
- sw (0x2B) with mem_ready=0 for 3 cycles in MEMWR -> state 5 held for 4 cycles with mem_write=1 throughout. reg_write is never asserted. Total 7 cycles.
- beq with zero=1, then bne with zero=1 -> pc_en=1 for beq and pc_en=0 for bne in BRANCH, both with pc_source=01. retired increases by 2.
- Opcode 0x3F -> DECODE then HALT, with halted=1 for 10 or more cycles and no enables asserted. Asserting rst returns the block to FETCH.
- rst asserted in MEMRD of an lw -> next state FETCH with no reg_write pulse and retired unchanged at 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants and control-word bundle for the
// multi-cycle MIPS sequencing controller.
package mc_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_RWB     = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_ADDI_EX = 4'd10;
  localparam logic [3:0] S_ADDI_WB = 4'd11;
  localparam logic [3:0] S_HALT    = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore control word for each controller state; only
// FETCH and BRANCH look at live inputs.
module mc_output_decode
  import mc_pkg::*;
(
  input  logic [3:0] state,
  input  logic [5:0] op_q,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDI_WB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCS_ALUOUT;
        // bne branches on a non-zero difference
        ctrl.pc_en     = (op_q == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        ctrl.pc_source = PCS_JUMP;
        ctrl.pc_en     = 1'b1;
      end
      S_HALT: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: state register, captured
// opcode and retired-instruction counter.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  logic [3:0] state_d;
  logic [5:0] op_q;
  logic       retire;
  ctrl_t      ctrl;

  always_comb begin
    state_d = state;
    case (state)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_LW) || (opcode == OP_SW):
            state_d = S_MEMADR;
          (opcode == OP_RTYPE):
            state_d = S_EXEC;
          (opcode == OP_BEQ) || (opcode == OP_BNE):
            state_d = S_BRANCH;
          (opcode == OP_J):
            state_d = S_JUMP;
          (opcode == OP_ADDI):
            state_d = S_ADDI_EX;
          default:
            state_d = S_HALT;
        endcase
      end
      S_MEMADR:
        state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:    state_d = S_RWB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_MEMWB, S_RWB, S_ADDI_WB, S_BRANCH, S_JUMP:
        state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEMWB, S_RWB, S_ADDI_WB, S_BRANCH, S_JUMP:
        retire = 1'b1;
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      op_q    <= '0;
      retired <= '0;
    end else begin
      state <= state_d;
      if (state == S_DECODE) op_q <= opcode;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  mc_output_decode u_dec (
    .state     (state),
    .op_q      (op_q),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // enables gated so nothing is written while reset is held
  assign pc_en      = ctrl.pc_en     & ~rst;
  assign ir_write   = ctrl.ir_write  & ~rst;
  assign mem_read   = ctrl.mem_read  & ~rst;
  assign mem_write  = ctrl.mem_write & ~rst;
  assign reg_write  = ctrl.reg_write & ~rst;
  assign i_or_d     = ctrl.i_or_d;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;
  assign halted     = ctrl.halted;

endmodule
